demux4_buf: RTL

//   Registered 1-to-4 demultiplexer with valid/ready handshakes. It is the inverse of mux4.

---
 rtl/demux4_buf_if.sv | 42 ++++
 rtl/demux4_buf.sv | 65 ++++++
 2 files changed

// File: rtl/demux4_buf_if.sv
// Handshake bundle for demux4_buf: one producer port, four consumer lanes.
// The master modport is the producer/consumer side; the slave modport is the block.
interface demux4_buf_if #(
  parameter int n = 32
);
  logic [1:0]   S;
  logic [n-1:0] D;
  logic         IN_VALID;
  logic         IN_READY;
  logic [n-1:0] Y0;
  logic [n-1:0] Y1;
  logic [n-1:0] Y2;
  logic [n-1:0] Y3;
  logic [3:0]   OUT_VALID;
  logic [3:0]   OUT_READY;

  modport master (
    output S,
    output D,
    output IN_VALID,
    output OUT_READY,
    input  IN_READY,
    input  Y0,
    input  Y1,
    input  Y2,
    input  Y3,
    input  OUT_VALID
  );

  modport slave (
    input  S,
    input  D,
    input  IN_VALID,
    input  OUT_READY,
    output IN_READY,
    output Y0,
    output Y1,
    output Y2,
    output Y3,
    output OUT_VALID
  );
endinterface

// File: rtl/demux4_buf.sv
// Registered 1-to-4 demultiplexer: each word is steered by S into a
// one-entry per-lane buffer and held until that lane's consumer takes it.
module demux4_buf #(
  parameter int n = 32
) (
  input  logic          CLOCK,
  input  logic          nRESET,
  demux4_buf_if.slave   bus
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]   r_state [4];
  logic [n-1:0] r_y     [4];

  logic [3:0] w_valid;
  logic [3:0] w_load;
  logic [3:0] w_drain;
  logic       w_sel_busy;
  logic       w_in_ready;
  logic       w_accept;

  // Only the addressed lane can stall the producer.
  assign w_sel_busy = w_valid[bus.S] & ~bus.OUT_READY[bus.S];
  assign w_in_ready = nRESET & ~w_sel_busy;
  assign w_accept   = bus.IN_VALID & w_in_ready;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic w_drain_only;

    assign w_valid[g] = (r_state[g] == FULL);
    assign w_load[g]  = w_accept & (bus.S == 2'(g));
    assign w_drain[g] = w_valid[g] & bus.OUT_READY[g];
    // A reload in the drain cycle wins, so the lane never bubbles.
    assign w_drain_only = w_drain[g] & ~w_load[g];

    always_ff @(posedge CLOCK or negedge nRESET) begin
      if (!nRESET) begin
        r_state[g] <= EMPTY;
        r_y[g]     <= '0;
      end else begin
        unique case (1'b1)
          w_load[g]: begin
            r_state[g] <= FULL;
            r_y[g]     <= bus.D;
          end
          w_drain_only: begin
            r_state[g] <= EMPTY;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.IN_READY  = w_in_ready;
  assign bus.OUT_VALID = w_valid;
  assign bus.Y0        = r_y[0];
  assign bus.Y1        = r_y[1];
  assign bus.Y2        = r_y[2];
  assign bus.Y3        = r_y[3];

endmodule
